dmem_arbiter: RTL and testbench

//   Shares the single-port data SRAM (CEN/WEN/OEN/A/Data2Mem/ReadDataMem) between two masters.

---
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data SRAM between two masters.
// SRAM controls are registered; read data returns in issue order via a tagged pipe.
module dmem_arbiter #(
  parameter int AW     = 7,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] Data2Mem,
  input  logic [DW-1:0] ReadDataMem
);

  logic              last;
  logic              grant_any;
  logic              grant_port;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_port;
  logic              ret_vld;
  logic              ret_port;

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    m0_gnt     = m0_req & (~m1_req | last);
    m1_gnt     = m1_req & (~m0_req | ~last);
    grant_any  = m0_gnt | m1_gnt;
    grant_port = m1_gnt;
    sel_we     = grant_port ? m1_we    : m0_we;
    sel_addr   = grant_port ? m1_addr  : m0_addr;
    sel_wdata  = grant_port ? m1_wdata : m0_wdata;
  end

  assign ret_vld  = pipe_vld[RD_LAT-1];
  assign ret_port = pipe_port[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      CEN       <= 1'b1;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      A         <= '0;
      Data2Mem  <= '0;
      pipe_vld  <= '0;
      pipe_port <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      if (grant_any) begin
        last     <= grant_port;
        CEN      <= 1'b0;
        A        <= sel_addr;
        WEN      <= ~sel_we;
        OEN      <= sel_we;
        Data2Mem <= sel_we ? sel_wdata : '0;
      end else begin
        CEN <= 1'b1;
        WEN <= 1'b1;
        OEN <= 1'b1;
      end

      // Stage k holds the read launched k+1 cycles ago; the last stage is sampled now.
      pipe_vld[0]  <= grant_any & ~sel_we;
      pipe_port[0] <= grant_port;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_port[i] <= pipe_port[i-1];
      end

      m0_rvalid <= ret_vld & ~ret_port;
      m1_rvalid <= ret_vld & ret_port;
      if (ret_vld && !ret_port) m0_rdata <= ReadDataMem;
      if (ret_vld && ret_port)  m1_rdata <= ReadDataMem;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT 1 and 3) share one stimulus stream,
// each with its own SRAM model and a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int NW = 2**AW;

  typedef struct {
    bit            idle;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } item_t;

  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic          m0_we = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;

  int vec  = 0;
  int errs = 0;

  item_t q0[$];
  item_t q1[$];
  bit    gs0 = 1'b0, gs1 = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] initv(input int i);
    return (i * 32'h9E3779B1) + 32'h01234567;
  endfunction

  function automatic item_t mk(input bit idle, input bit we, input int addr, input logic [DW-1:0] d);
    item_t it;
    it.idle  = idle;
    it.we    = we;
    it.addr  = addr[AW-1:0];
    it.wdata = d;
    return it;
  endfunction

  function automatic item_t rnd_item();
    int r;
    int a;
    r = $urandom_range(0, 9);
    if (r == 0)      a = 0;
    else if (r == 1) a = NW - 1;
    else if (r < 6)  a = $urandom_range(0, 7);
    else             a = $urandom_range(0, NW - 1);
    return mk($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, $urandom);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic          g0, g1, rv0, rv1, cen, wen, oen;
    logic [DW-1:0] rd0, rd1, d2m, rdm, rd_now, dl0, dl1;
    logic [AW-1:0] a;
    logic [DW-1:0] smem [NW];

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(g0), .m0_rvalid(rv0), .m0_rdata(rd0),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(g1), .m1_rvalid(rv1), .m1_rdata(rd1),
      .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .Data2Mem(d2m), .ReadDataMem(rdm)
    );

    // SRAM: writes commit at the end of the enabled cycle; read data delayed by LAT-1 cycles.
    assign rd_now = (!cen && !oen) ? smem[a] : '0;
    assign rdm    = (LAT == 1) ? rd_now : (LAT == 2) ? dl0 : dl1;

    always @(posedge clk) begin
      dl0 <= rd_now;
      dl1 <= dl0;
      if (!rst_n) begin
        for (int i = 0; i < NW; i++) smem[i] <= initv(i);
      end else if (!cen && !wen) begin
        smem[a] <= d2m;
      end
    end

    // Reference model: transactions are committed at grant time.
    resp_t         rq[$];
    resp_t         r;
    logic [DW-1:0] mm [NW];
    bit            last;
    int            cyc = 0;
    logic          e_cen, e_wen, e_oen;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, e_rd0, e_rd1;
    bit            win, w, eg0, eg1, ev0, ev1;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;

    always @(posedge clk) begin
      if (!rst_n) begin
        last = 1'b1;
        rq.delete();
        e_cen = 1'b1; e_wen = 1'b1; e_oen = 1'b1;
        e_a = '0; e_d = '0; e_rd0 = '0; e_rd1 = '0;
        for (int i = 0; i < NW; i++) mm[i] = initv(i);
      end else if (m0_req || m1_req) begin
        win = (m0_req && m1_req) ? !last : m1_req;
        w   = win ? m1_we    : m0_we;
        ad  = win ? m1_addr  : m0_addr;
        wd  = win ? m1_wdata : m0_wdata;
        e_cen = 1'b0; e_a = ad; e_wen = !w; e_oen = w;
        e_d = w ? wd : '0;
        if (w) mm[ad] = wd;
        else   rq.push_back('{cyc + 1 + LAT, win, mm[ad]});
        last = win;
      end else begin
        e_cen = 1'b1; e_wen = 1'b1; e_oen = 1'b1;
      end
      cyc++;
    end

    always @(negedge clk) begin
      ev0 = 1'b0;
      ev1 = 1'b0;
      if (!rst_n) begin
        rq.delete();
        e_cen = 1'b1; e_wen = 1'b1; e_oen = 1'b1;
        e_a = '0; e_d = '0; e_rd0 = '0; e_rd1 = '0;
      end else begin
        if (m0_req && m1_req) begin
          eg0 = last; eg1 = !last;
        end else begin
          eg0 = m0_req; eg1 = m1_req;
        end
        check($sformatf("L%0d m0_gnt", LAT), DW'(g0), DW'(eg0));
        check($sformatf("L%0d m1_gnt", LAT), DW'(g1), DW'(eg1));
        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          if (r.port) begin ev1 = 1'b1; e_rd1 = r.data; end
          else        begin ev0 = 1'b1; e_rd0 = r.data; end
        end
      end
      check($sformatf("L%0d CEN", LAT), DW'(cen), DW'(e_cen));
      check($sformatf("L%0d WEN", LAT), DW'(wen), DW'(e_wen));
      check($sformatf("L%0d OEN", LAT), DW'(oen), DW'(e_oen));
      check($sformatf("L%0d A", LAT), DW'(a), DW'(e_a));
      check($sformatf("L%0d Data2Mem", LAT), d2m, e_d);
      check($sformatf("L%0d m0_rvalid", LAT), DW'(rv0), DW'(ev0));
      check($sformatf("L%0d m1_rvalid", LAT), DW'(rv1), DW'(ev1));
      check($sformatf("L%0d m0_rdata", LAT), rd0, e_rd0);
      check($sformatf("L%0d m1_rdata", LAT), rd1, e_rd1);
    end
  end

  always @(negedge clk) begin
    gs0 = inst[0].g0;
    gs1 = inst[0].g1;
  end

  // Called just after a rising edge: a port takes its next item once idle or granted.
  task automatic drive();
    item_t it;
    if (!m0_req || gs0) begin
      if (q0.size() > 0) begin
        it = q0.pop_front();
        m0_req = !it.idle; m0_we = it.we; m0_addr = it.addr; m0_wdata = it.wdata;
      end else m0_req = 1'b0;
    end
    if (!m1_req || gs1) begin
      if (q1.size() > 0) begin
        it = q1.pop_front();
        m1_req = !it.idle; m1_we = it.we; m1_addr = it.addr; m1_wdata = it.wdata;
      end else m1_req = 1'b0;
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    do begin
      @(posedge clk); #1;
      drive();
      n++;
    end while ((q0.size() > 0 || q1.size() > 0 || m0_req || m1_req) && n < maxc);
    check("drain_in_budget", DW'(n < maxc), DW'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    q0.push_back(mk(0, 1, 'h7F, 32'hDEADBEEF));
    q0.push_back(mk(0, 0, 'h7F, '0));
    drain(50);
    idle(6);

    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(0, $urandom_range(0, 1) == 1, $urandom_range(0, NW - 1), $urandom));
      q1.push_back(mk(0, $urandom_range(0, 1) == 1, $urandom_range(0, NW - 1), $urandom));
    end
    drain(100);
    idle(6);

    for (int i = 0; i < 4; i++) q1.push_back(mk(0, 0, i, '0));
    drain(50);
    idle(6);

    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, 0, $urandom_range(0, NW - 1), '0));
      q1.push_back(mk(0, 0, $urandom_range(0, NW - 1), '0));
    end
    drain(50);
    idle(6);

    // Reset lands in the cycle the read is launched; its response must never appear.
    q0.push_back(mk(0, 0, 'h10, '0));
    drain(20);
    rst_n = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);

    for (int i = 0; i < 1500; i++) begin
      q0.push_back(rnd_item());
      q1.push_back(rnd_item());
    end
    drain(20000);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
